tx_fifo_arbiter: RTL

Shares the single host CCI-P transmit port among `N_AFU` requesters. Each requester's per-channel Tx FIFOs (c0 read requests, c1 write requests, c2 MMIO read responses) present `notEmpty`/`first` and accept `deq_en`. The block round-robin arbitrates each channel independently, keeps multi-line c1 writes atomic, honours host almost-full, tags c0/c1 mdata with the requester index, and drives one registered `t_if_ccip_Tx`. It sits between the per-AFU Tx FIFO stages and the shim's host Tx port in the vai mux.

---
 rtl/ccip_mux_pkg.sv | 91 +++++++++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/tx_fifo_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ccip_mux_pkg.sv
// ccip_mux_pkg
//   Shared types for the CCI-P Tx mux. The CCI-P headers here are a compact
//   model of the host interface: only the fields the mux forwards or inspects.
//   The c1 data line is carried as a 64-bit payload.
//   Contents: requester index type, mdata tag position, request/length enums,
//   per-channel Tx structs, the c1 arbiter state enum and is_c1_write().
package ccip_mux_pkg;

    localparam int MUX_TAG_MSB   = 15;
    localparam int MUX_MAX_IDX_W = 3;     // up to 8 requesters

    typedef logic [MUX_MAX_IDX_W-1:0] t_mux_idx;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef struct packed {
        logic [1:0]   vc_sel;
        logic [1:0]   rsvd;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [41:0]  address;
        logic [15:0]  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [1:0]   vc_sel;
        logic         sop;
        logic         rsvd;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [41:0]  address;
        logic [15:0]  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [63:0]        data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    typedef enum logic {
        C1_IDLE  = 1'b0,
        C1_BURST = 1'b1
    } t_c1_arb_state;

    // Request types that carry data lines and may therefore span several beats.
    function automatic logic is_c1_write(input t_ccip_c1_req req_type);
        return (req_type == eREQ_WRLINE_I) ||
               (req_type == eREQ_WRLINE_M) ||
               (req_type == eREQ_WRPUSH_I);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter with a rotating priority pointer. The winner is the
//   first requester at or after ptr. ptr moves to winner+1 (mod N) only when
//   the caller marks the grant as complete with advance.
//   Ports: clk, reset (sync, active-high), req[N], enable (gates the grant),
//          advance (complete grant, move ptr), grant[N] one-hot, grant_idx.
module rr_arbiter #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         enable,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);

    logic [W-1:0] ptr;
    logic [W-1:0] cand;
    logic         found;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        grant     = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = W'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (enable && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && enable && found) begin
            if (int'(grant_idx) == N - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + W'(1);
            end
        end
    end

endmodule

// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter
//   Shares one CCI-P Tx port among N_AFU requesters. Each channel (c0 reads,
//   c1 writes, c2 MMIO responses) has its own round-robin arbiter; c1 locks
//   onto the owner of a multi-line write until its last beat. Heads are
//   registered onto out_TxPort one cycle after the dequeue.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     in_fifo_cX_notEmpty/first  per-requester FIFO status and head
//     out_fifo_cX_deq_en         per-requester dequeue, one-hot or zero
//     in_c0TxAlmFull/c1TxAlmFull host almost-full
//     out_TxPort                 registered host Tx
//     out_c1_grant_idx           current or last c1 owner
//     out_err_c1_sop             sticky: sop=0 head seen outside a burst
//     out_c1_state               c1 arbiter state
//
//   Handshake: a requester's head is consumed in the cycle its deq_en is high;
//   deq_en is only raised for a requester whose notEmpty is high.
module tx_fifo_arbiter
    import ccip_mux_pkg::*;
#(
    parameter int N_AFU     = 2,
    parameter int IDX_W     = $clog2(N_AFU),
    parameter int TAG_MDATA = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_AFU-1:0]     in_fifo_c0_notEmpty,
    input  t_if_ccip_c0_Tx       in_fifo_c0_first [N_AFU],
    output logic [N_AFU-1:0]     out_fifo_c0_deq_en,
    input  logic [N_AFU-1:0]     in_fifo_c1_notEmpty,
    input  t_if_ccip_c1_Tx       in_fifo_c1_first [N_AFU],
    output logic [N_AFU-1:0]     out_fifo_c1_deq_en,
    input  logic [N_AFU-1:0]     in_fifo_c2_notEmpty,
    input  t_if_ccip_c2_Tx       in_fifo_c2_first [N_AFU],
    output logic [N_AFU-1:0]     out_fifo_c2_deq_en,
    input  logic                 in_c0TxAlmFull,
    input  logic                 in_c1TxAlmFull,
    output t_if_ccip_Tx          out_TxPort,
    output logic [IDX_W-1:0]     out_c1_grant_idx,
    output logic                 out_err_c1_sop,
    output t_c1_arb_state        out_c1_state
);

    logic [N_AFU-1:0] c0_grant, c1_grant, c2_grant;
    logic [IDX_W-1:0] c0_idx, c1_idx, c2_idx;

    // c1 burst lock state
    t_c1_arb_state    c1_state, c1_state_nxt;
    logic [IDX_W-1:0] c1_owner, c1_owner_nxt;
    logic [1:0]       beats_left, beats_left_nxt;
    logic [IDX_W-1:0] c1_grant_idx_q;
    logic             err_sop_q;

    logic [N_AFU-1:0] owner_mask;
    logic [N_AFU-1:0] c1_req;
    logic             c1_advance;
    logic             c1_fire;
    logic             err_set;
    t_if_ccip_c1_Tx   c1_head;
    t_if_ccip_Tx      tx_nxt;

    // ---------------- arbiters ----------------
    rr_arbiter #(.N(N_AFU), .W(IDX_W)) u_arb_c0 (
        .clk       (clk),
        .reset     (reset),
        .req       (in_fifo_c0_notEmpty),
        .enable    (!reset && !in_c0TxAlmFull),
        .advance   (1'b1),
        .grant     (c0_grant),
        .grant_idx (c0_idx)
    );

    // During a burst only the owner may win; ptr is held until the last beat.
    always_comb begin
        owner_mask           = '0;
        owner_mask[c1_owner] = 1'b1;
    end

    assign c1_req = (c1_state == C1_BURST) ? (in_fifo_c1_notEmpty & owner_mask)
                                           : in_fifo_c1_notEmpty;

    rr_arbiter #(.N(N_AFU), .W(IDX_W)) u_arb_c1 (
        .clk       (clk),
        .reset     (reset),
        .req       (c1_req),
        .enable    (!reset && !in_c1TxAlmFull),
        .advance   (c1_advance),
        .grant     (c1_grant),
        .grant_idx (c1_idx)
    );

    rr_arbiter #(.N(N_AFU), .W(IDX_W)) u_arb_c2 (
        .clk       (clk),
        .reset     (reset),
        .req       (in_fifo_c2_notEmpty),
        .enable    (!reset),
        .advance   (1'b1),
        .grant     (c2_grant),
        .grant_idx (c2_idx)
    );

    assign out_fifo_c0_deq_en = c0_grant;
    assign out_fifo_c1_deq_en = c1_grant;
    assign out_fifo_c2_deq_en = c2_grant;

    // ---------------- c1 burst FSM ----------------
    assign c1_fire = |c1_grant;
    assign c1_head = in_fifo_c1_first[c1_idx];

    always_comb begin
        c1_state_nxt   = c1_state;
        c1_owner_nxt   = c1_owner;
        beats_left_nxt = beats_left;
        c1_advance     = 1'b0;
        err_set        = 1'b0;
        case (c1_state)
            C1_IDLE: begin
                if (c1_fire) begin
                    if (is_c1_write(c1_head.hdr.req_type) && c1_head.hdr.sop &&
                        (c1_head.hdr.cl_len != eCL_LEN_1)) begin
                        // cl_len encodes lines-1, i.e. the beats still owed.
                        c1_state_nxt   = C1_BURST;
                        c1_owner_nxt   = c1_idx;
                        beats_left_nxt = c1_head.hdr.cl_len;
                    end else begin
                        c1_advance = 1'b1;
                        err_set    = !c1_head.hdr.sop;
                    end
                end
            end
            C1_BURST: begin
                if (c1_fire) begin
                    beats_left_nxt = beats_left - 2'd1;
                    if (beats_left == 2'd1) begin
                        c1_state_nxt = C1_IDLE;
                        c1_advance   = 1'b1;
                    end
                end
            end
            default: c1_state_nxt = C1_IDLE;
        endcase
    end

    // ---------------- output staging ----------------
    always_comb begin
        tx_nxt = '0;
        if (|c0_grant) begin
            tx_nxt.c0       = in_fifo_c0_first[c0_idx];
            tx_nxt.c0.valid = 1'b1;
            if (TAG_MDATA != 0) begin
                tx_nxt.c0.hdr.mdata[MUX_TAG_MSB -: IDX_W] = c0_idx;
            end
        end
        if (c1_fire) begin
            tx_nxt.c1       = c1_head;
            tx_nxt.c1.valid = 1'b1;
            if (TAG_MDATA != 0) begin
                tx_nxt.c1.hdr.mdata[MUX_TAG_MSB -: IDX_W] = c1_idx;
            end
        end
        if (|c2_grant) begin
            tx_nxt.c2             = in_fifo_c2_first[c2_idx];
            tx_nxt.c2.mmioRdValid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_TxPort     <= '0;
            c1_state       <= C1_IDLE;
            c1_owner       <= '0;
            beats_left     <= '0;
            c1_grant_idx_q <= '0;
            err_sop_q      <= 1'b0;
        end else begin
            out_TxPort <= tx_nxt;
            c1_state   <= c1_state_nxt;
            c1_owner   <= c1_owner_nxt;
            beats_left <= beats_left_nxt;
            if (c1_fire) begin
                c1_grant_idx_q <= c1_idx;
            end
            if (err_set) begin
                err_sop_q <= 1'b1;
            end
        end
    end

    assign out_c1_grant_idx = c1_grant_idx_q;
    assign out_err_c1_sop   = err_sop_q;
    assign out_c1_state     = c1_state;

endmodule
